// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, with pipeline stall request
module muldiv_seq #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] FIX  = 2'd2;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] p;
    logic [WIDTH-1:0]   rem, opb, raw_a;
    logic               is_div, neg_q, neg_r, div_zero;
    logic [WIDTH-1:0]   abs_a, abs_b, quo, rmd;
    logic [WIDTH:0]     add_up, trial, diff;
    logic [2*WIDTH-1:0] prod;

    assign busy  = state != IDLE;
    assign stall = busy & (start | rd_hilo | wr_hi | wr_lo);
    assign abs_a = (op[0] && a[WIDTH-1]) ? -a : a;
    assign abs_b = (op[0] && b[WIDTH-1]) ? -b : b;
    // Multiply: p = {partial product, remaining multiplier bits}, consumed LSB first
    assign add_up = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, opb} : '0);
    // Divide: p[WIDTH-1:0] shifts dividend bits out and quotient bits in
    assign trial = {rem, p[WIDTH-1]};
    assign diff  = trial - {1'b0, opb};
    assign prod  = neg_q ? -p : p;
    assign quo   = neg_q ? -p[WIDTH-1:0] : p[WIDTH-1:0];
    assign rmd   = neg_r ? -rem : rem;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            p        <= '0;
            rem      <= '0;
            opb      <= '0;
            raw_a    <= '0;
            is_div   <= 1'b0;
            neg_q    <= 1'b0;
            neg_r    <= 1'b0;
            div_zero <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= state == FIX;
            case (state)
                IDLE: begin
                    if (start) begin
                        p        <= {{WIDTH{1'b0}}, op[1] ? abs_a : abs_b};
                        opb      <= op[1] ? abs_b : abs_a;
                        rem      <= '0;
                        cnt      <= '0;
                        is_div   <= op[1];
                        neg_q    <= op[0] & (a[WIDTH-1] ^ b[WIDTH-1]);
                        neg_r    <= op[0] & a[WIDTH-1];
                        div_zero <= b == '0;
                        raw_a    <= a;
                        state    <= CALC;
                    end else begin
                        if (wr_hi) hi <= wd;
                        if (wr_lo) lo <= wd;
                    end
                end
                CALC: begin
                    if (is_div) begin
                        rem           <= diff[WIDTH] ? trial[WIDTH-1:0] : diff[WIDTH-1:0];
                        p[WIDTH-1:0]  <= {p[WIDTH-2:0], ~diff[WIDTH]};
                    end else begin
                        p <= {add_up, p[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) state <= FIX;
                end
                FIX: begin
                    hi    <= is_div ? (div_zero ? raw_a : rmd) : prod[2*WIDTH-1:WIDTH];
                    lo    <= is_div ? (div_zero ? '1 : quo) : prod[WIDTH-1:0];
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: table-driven result/latency checks plus hand-written stall, replay and reset sequences
module tb_muldiv_seq;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset, start, rd_hilo, wr_hi, wr_lo;
    logic [1:0]   op;
    logic [W-1:0] a, b, wd, hi, lo;
    logic         busy, done, stall;
    int           n_checks = 0;
    int           n_fail = 0;

    typedef struct {
        logic [1:0]   op;
        logic [W-1:0] a, b, hi, lo;
    } vec_t;
    vec_t vecs[11];

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
        .rd_hilo(rd_hilo), .wr_hi(wr_hi), .wr_lo(wr_lo), .wd(wd),
        .busy(busy), .done(done), .stall(stall), .hi(hi), .lo(lo)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Counts edges from the one that samples start (edge 1) until done is seen
    task automatic wait_done(input int e0, output int edges);
        edges = e0;
        while (!done && edges < 100) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic issue(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y, output int edges);
        @(negedge clk);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(1, edges);
    endtask

    initial begin
        int    edges;
        logic  ok, seen;
        vecs[0]  = '{2'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
        vecs[1]  = '{2'd1, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFEB};
        vecs[2]  = '{2'd1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
        vecs[3]  = '{2'd2, 32'd100,      32'd7,        32'd2,        32'd14};
        vecs[4]  = '{2'd3, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD};
        vecs[5]  = '{2'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000};
        vecs[6]  = '{2'd2, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF};
        vecs[7]  = '{2'd3, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD};
        vecs[8]  = '{2'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};
        vecs[9]  = '{2'd3, 32'hFFFFFFF9, 32'd0,        32'hFFFFFFF9, 32'hFFFFFFFF};
        vecs[10] = '{2'd0, 32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780};

        reset = 1'b1; start = 1'b0; rd_hilo = 1'b0; wr_hi = 1'b0; wr_lo = 1'b0;
        op = 2'd0; a = '0; b = '0; wd = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_stall", stall, 0);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, edges);
            check($sformatf("vec%0d_latency", i), edges, W + 2);
            check($sformatf("vec%0d_hi", i), hi, vecs[i].hi);
            check($sformatf("vec%0d_lo", i), lo, vecs[i].lo);
            @(posedge clk);
            #1;
            check($sformatf("vec%0d_done_pulse", i), done, 0);
        end

        @(negedge clk);
        wr_hi = 1'b1; wd = 32'hAAAA0000;
        check("mthi_idle_stall", stall, 0);
        @(posedge clk);
        #1;
        wr_hi = 1'b0; wr_lo = 1'b1; wd = 32'h0000BBBB;
        check("mthi_idle", hi, 32'hAAAA0000);
        @(posedge clk);
        #1;
        wr_lo = 1'b0;
        check("mtlo_idle", lo, 32'h0000BBBB);

        @(negedge clk);
        op = 2'd0; a = 32'd6; b = 32'd7; start = 1'b1; wr_lo = 1'b1; wd = 32'h5555;
        @(posedge clk);
        #1;
        start = 1'b0; wr_lo = 1'b0;
        check("start_wins_lo_held", lo, 32'h0000BBBB);
        wait_done(1, edges);
        check("start_wins_lo", lo, 42);

        @(negedge clk);
        op = 2'd0; a = 32'd3; b = 32'd4; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; rd_hilo = 1'b1; ok = 1'b1; edges = 1;
        while (!done && edges < 100) begin
            @(negedge clk);
            if (stall !== 1'b1 || busy !== 1'b1) ok = 1'b0;
            @(posedge clk);
            #1;
            edges++;
        end
        check("rd_hilo_stall_busy", ok, 1);
        check("rd_hilo_done_stall", stall, 0);
        check("rd_hilo_latency", edges, W + 2);
        check("rd_hilo_lo", lo, 12);
        rd_hilo = 1'b0;

        @(negedge clk);
        op = 2'd2; a = 32'd100; b = 32'd7; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0; edges = 1;
        repeat (4) begin
            @(posedge clk);
            #1;
            edges++;
        end
        start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3; wr_lo = 1'b1; wd = 32'hDEAD;
        #1;
        check("busy_start_stall", stall, 1);
        @(posedge clk);
        #1;
        edges++;
        start = 1'b0; wr_lo = 1'b0;
        check("busy_wr_lo_ignored", lo, 12);
        wait_done(edges, edges);
        check("restart_ignored_latency", edges, W + 2);
        check("restart_ignored_lo", lo, 14);
        check("restart_ignored_hi", hi, 2);

        @(negedge clk);
        op = 2'd0; a = 32'hFFFFFFFF; b = 32'd2; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("abort_busy", busy, 0);
        check("abort_hi", hi, 0);
        check("abort_lo", lo, 0);
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
        check("abort_no_done", seen, 0);
        issue(2'd0, 32'd6, 32'd7, edges);
        check("post_abort_latency", edges, W + 2);
        check("post_abort_lo", lo, 42);
        check("post_abort_hi", hi, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
